// File: rtl/gcd_feeder.sv
// Flow-controlled front end for the gcd unit: operand FIFO, one job in flight,
// {a,b,gcd} result on a valid/ready port. Optional watchdog: GCD_FEEDER_TIMEOUT_EN.
module gcd_feeder #(
  parameter int unsigned N       = 8,
  parameter int unsigned LOGN    = 3,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_a,
  input  logic [N-1:0]             in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_a,
  output logic [N-1:0]             out_b,
  output logic [N-1:0]             out_gcd,
  output logic                     out_err,
  output logic                     gcd_start,
  output logic [N-1:0]             gcd_a,
  output logic [N-1:0]             gcd_b,
  input  logic                     gcd_busy,
  input  logic [N-1:0]             gcd_o,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (LOGN != $clog2(N) || DEPTH < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("gcd_feeder: inconsistent parameters");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  mem_a [DEPTH];
  logic [N-1:0]  mem_b [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, capture, out_clear;

  assign in_ready  = fifo_count < CW'(DEPTH);
  assign push      = in_valid && in_ready;
  assign gcd_start = (state == ISSUE);

`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  logic          fire;
`else
  assign out_err = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    capture   = 1'b0;
    out_clear = 1'b0;
`ifdef GCD_FEEDER_TIMEOUT_EN
    fire      = 1'b0;
`endif
    case (state)
      // IDLE also waits out a gcd job left running across a reset
      IDLE: if (fifo_count != '0 && !gcd_busy) begin
        pop     = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: if (!gcd_busy) state_n = WAIT;
      WAIT: begin
        if (!gcd_busy) begin
          capture = 1'b1;
          state_n = OUT;
        end
`ifdef GCD_FEEDER_TIMEOUT_EN
        else if (wd == WW'(TIMEOUT - 1)) begin
          fire    = 1'b1;
          state_n = OUT;
        end
`endif
      end
      OUT: if (out_ready) begin
        out_clear = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      gcd_a      <= '0;
      gcd_b      <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_gcd    <= '0;
    end else begin
      state      <= state_n;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        gcd_a  <= mem_a[rd_ptr];
        gcd_b  <= mem_b[rd_ptr];
      end
      if (capture) begin
        out_gcd   <= gcd_o;
        out_a     <= gcd_a;
        out_b     <= gcd_b;
        out_valid <= 1'b1;
      end
`ifdef GCD_FEEDER_TIMEOUT_EN
      if (fire) begin
        out_gcd   <= '0;
        out_a     <= gcd_a;
        out_b     <= gcd_b;
        out_valid <= 1'b1;
      end
`endif
      if (out_clear) out_valid <= 1'b0;
    end
  end

`ifdef GCD_FEEDER_TIMEOUT_EN
  // wd counts completed WAIT cycles; held at zero outside a job
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd      <= '0;
      out_err <= 1'b0;
    end else begin
      if (state == WAIT) wd <= wd + 1'b1;
      else               wd <= '0;
      if (fire)           out_err <= 1'b1;
      else if (out_clear) out_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_feeder.sv
// Self-checking bench for gcd_feeder: behavioural gcd responder, queue-based
// reference of FIFO contents and in-order results, directed + random steps.
module tb_gcd_feeder;
  localparam int unsigned N = 8;
  localparam int unsigned DEPTH = 4;
`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 4;
`else
  localparam int unsigned TB_TIMEOUT = 64;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [N-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_err, gcd_start;
  logic [N-1:0] out_a, out_b, out_gcd, gcd_a, gcd_b;
  logic gcd_busy = 1'b0;
  logic [N-1:0] gcd_o = '0;
  logic [$clog2(DEPTH):0] fifo_count;

  gcd_feeder #(.N(N), .LOGN(3), .DEPTH(DEPTH), .TIMEOUT(TB_TIMEOUT)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_gcd(out_gcd), .out_err(out_err),
    .gcd_start(gcd_start), .gcd_a(gcd_a), .gcd_b(gcd_b),
    .gcd_busy(gcd_busy), .gcd_o(gcd_o), .fifo_count(fifo_count));

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_gcd(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned x = a, y = b, t;
    if (x == 0 || y == 0) return '0;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return N'(x);
  endfunction

  // Behavioural gcd unit: never reset, fixed or random latency, optional hang
  int env_lat = 0;
  logic hang = 1'b0;
  int rem = 0;
  logic [N-1:0] res = '0;
  always @(posedge clock) begin
    if (!gcd_busy) begin
      if (gcd_start) begin
        gcd_busy <= 1'b1;
        res      <= ref_gcd(gcd_a, gcd_b);
        rem      <= (env_lat != 0) ? env_lat : int'($urandom_range(0, 5));
      end
    end else if (!hang) begin
      if (rem == 0) begin gcd_o <= res; gcd_busy <= 1'b0; end
      else rem <= rem - 1;
    end
  end

  typedef struct { logic [N-1:0] a; logic [N-1:0] b; } pair_t;
  pair_t fifo_q[$];
  pair_t res_q[$];
  pair_t pend_pair, p;
  logic pend = 1'b0, prev_start = 1'b0, prev_busy = 1'b0;
  logic prev_ov = 1'b0, prev_or = 1'b0;
  logic [N-1:0] prev_a, prev_b, prev_g;
  logic prev_e;

  // Reference model: operand queue, in-flight/result queue, output checks
  always @(negedge clock) begin
    if (!reset_n) begin
      fifo_q.delete();
      res_q.delete();
      pend = 1'b0;
      prev_start = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (pend) fifo_q.push_back(pend_pair);
      if (gcd_start && !prev_start) begin
        chk("issue_while_busy", 32'(prev_busy), 0);
        chk("issue_from_empty", 32'(fifo_q.size() != 0), 1);
        if (fifo_q.size() != 0) begin
          p = fifo_q.pop_front();
          chk("gcd_a", 32'(gcd_a), 32'(p.a));
          chk("gcd_b", 32'(gcd_b), 32'(p.b));
          res_q.push_back(p);
        end
      end
      chk("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
      chk("in_ready", 32'(in_ready), 32'(fifo_q.size() < DEPTH));
      if (prev_ov && !prev_or) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_a", 32'(out_a), 32'(prev_a));
        chk("hold_b", 32'(out_b), 32'(prev_b));
        chk("hold_gcd", 32'(out_gcd), 32'(prev_g));
        chk("hold_err", 32'(out_err), 32'(prev_e));
      end
`ifndef GCD_FEEDER_TIMEOUT_EN
      chk("err_tied", 32'(out_err), 0);
`endif
      if (out_valid && out_ready) begin
        chk("result_avail", 32'(res_q.size() != 0), 1);
        if (res_q.size() != 0) begin
          p = res_q.pop_front();
          chk("out_a", 32'(out_a), 32'(p.a));
          chk("out_b", 32'(out_b), 32'(p.b));
`ifdef GCD_FEEDER_TIMEOUT_EN
          chk("out_err", 32'(out_err), 32'(hang));
          chk("out_gcd", 32'(out_gcd), hang ? 32'd0 : 32'(ref_gcd(p.a, p.b)));
`else
          chk("out_gcd", 32'(out_gcd), 32'(ref_gcd(p.a, p.b)));
`endif
        end
      end
      pend = in_valid && in_ready;
      pend_pair.a = in_a;
      pend_pair.b = in_b;
      prev_start = gcd_start;
      prev_ov = out_valid;
      prev_or = out_ready;
      prev_a = out_a; prev_b = out_b; prev_g = out_gcd; prev_e = out_err;
    end
    prev_busy = gcd_busy;
  end

  task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
    int n = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 300) begin @(negedge clock); n++; end
    chk("push_bound", 32'(n < 300), 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    @(negedge clock);
    while (!out_valid && n < 200) begin @(negedge clock); n++; end
    chk("out_valid_bound", 32'(n < 200), 1);
  endtask

  task automatic wait_start(input logic lvl);
    int n = 0;
    @(negedge clock);
    while (gcd_start !== lvl && n < 200) begin @(negedge clock); n++; end
    chk("start_bound", 32'(n < 200), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while ((fifo_q.size() != 0 || res_q.size() != 0 || pend || out_valid) && n < 3000) begin
      @(negedge clock); n++;
    end
    chk("drain_bound", 32'(n < 3000), 1);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_out_b", 32'(out_b), 0);
    chk("rst_out_gcd", 32'(out_gcd), 0);
    chk("rst_out_err", 32'(out_err), 0);
    chk("rst_start", 32'(gcd_start), 0);
    chk("rst_gcd_a", 32'(gcd_a), 0);
    chk("rst_gcd_b", 32'(gcd_b), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk_reset_outputs();
    reset_n = 1'b1;
    @(posedge clock); #1;

    // T1 single job
    out_ready = 1'b1;
    push(8'd12, 8'd18);
    wait_out_valid();
    chk("t1_gcd", 32'(out_gcd), 6);
    chk("t1_a", 32'(out_a), 12);
    chk("t1_b", 32'(out_b), 18);
    wait_idle();

    // T2 back-to-back, including a zero operand
    push(8'd36, 8'd24);
    push(8'd7, 8'd7);
    push(8'd0, 8'd5);
    wait_idle();

    // T3 fill the FIFO behind a stalled result
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(N'((i + 1) * 6), N'((i + 2) * 4));
    in_a = 8'd99; in_b = 8'd33; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t3_full_ready", 32'(in_ready), 0);
      chk("t3_full_count", 32'(fifo_count), DEPTH);
      chk("t3_held_valid", 32'(out_valid), 1);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    // T4 reset during WAIT with a slow gcd; stale job must drain unseen
    env_lat = 10;
    push(8'd36, 8'd24);
    wait_start(1'b1);
    wait_start(1'b0);
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(posedge clock); #1;
    chk_reset_outputs();
    chk("t4_gcd_still_busy", 32'(gcd_busy), 1);
    reset_n = 1'b1;
    env_lat = 0;
    push(8'd9, 8'd6);
    wait_out_valid();
    chk("t4_gcd", 32'(out_gcd), 3);
    chk("t4_a", 32'(out_a), 9);
    wait_idle();

    // T5 randomized traffic with random backpressure
    for (int i = 0; i < 200; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_a = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom);
      in_b = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle();

`ifdef GCD_FEEDER_TIMEOUT_EN
    // T6 watchdog on a gcd that never drops busy
    begin
      int n;
      hang = 1'b1;
      push(8'd20, 8'd5);
      wait_start(1'b1);
      wait_start(1'b0);
      n = 0;
      while (!out_valid && n < 50) begin n++; @(negedge clock); end
      chk("t6_wait_cycles", 32'(n), TB_TIMEOUT);
      chk("t6_err", 32'(out_err), 1);
      chk("t6_gcd", 32'(out_gcd), 0);
      @(negedge clock);
      hang = 1'b0;
      wait_idle();
      chk("t6_err_cleared", 32'(out_err), 0);
    end
`endif

    chk("final_fifo_empty", 32'(fifo_count), 0);
    chk("final_out_idle", 32'(out_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
